// File: rtl/loop_nest_sched_if.sv
// Bundle of request, iteration-stream and completion signals for loop_nest_sched.
//   req_valid/req_ready      : per-requester job handshake (bit i = requester i)
//   req{0,1}_bound{0,1}      : inner/outer trip counts offered by each requester
//   iter_valid/iter_ready    : iteration stream handshake
//   iter0/iter1/iter_last    : inner index, outer index, final-iteration flag
//   iter_owner               : requester owning the running job
//   done/done_owner          : one-cycle completion pulse and its requester
// The scheduler uses the slave modport; the control/datapath side uses master.
interface loop_nest_sched_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req0_bound0;
  logic [WIDTH-1:0] req0_bound1;
  logic [WIDTH-1:0] req1_bound0;
  logic [WIDTH-1:0] req1_bound1;
  logic             iter_valid;
  logic             iter_ready;
  logic [WIDTH-1:0] iter0;
  logic [WIDTH-1:0] iter1;
  logic             iter_last;
  logic             iter_owner;
  logic             done;
  logic             done_owner;

  modport master (
    output req_valid, req0_bound0, req0_bound1, req1_bound0, req1_bound1, iter_ready,
    input  req_ready, iter_valid, iter0, iter1, iter_last, iter_owner, done, done_owner
  );

  modport slave (
    input  req_valid, req0_bound0, req0_bound1, req1_bound0, req1_bound1, iter_ready,
    output req_ready, iter_valid, iter0, iter1, iter_last, iter_owner, done, done_owner
  );
endinterface

// File: rtl/loop_nest_sched.sv
// Two-requester scheduler for a shared two-level nested loop iterator.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : loop_nest_sched_if slave modport (job requests, iteration stream,
//         completion pulse)
// A job is granted round-robin in IDLE, then walks iter0 (inner) and iter1
// (outer) one step per accepted iteration, then spends one cycle in DONE.
module loop_nest_sched #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  loop_nest_sched_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] bound0_q, bound0_d;
  logic [WIDTH-1:0] bound1_q, bound1_d;
  logic [WIDTH-1:0] it0_q, it0_d;
  logic [WIDTH-1:0] it1_q, it1_d;

  logic [1:0]       gnt;
  logic             inner_wrap;
  logic             is_last;
  logic             hs;
  logic [WIDTH-1:0] sel_b0;
  logic [WIDTH-1:0] sel_b1;

  // Grant is combinational so a request can be accepted in its first IDLE cycle.
  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    gnt = 2'b00;
    if (state_q == S_IDLE) begin
      if (bus.req_valid == 2'b11) begin
        gnt = last_grant_q ? 2'b01 : 2'b10;
      end else begin
        gnt = bus.req_valid;
      end
    end
  end

  assign sel_b0     = gnt[1] ? bus.req1_bound0 : bus.req0_bound0;
  assign sel_b1     = gnt[1] ? bus.req1_bound1 : bus.req0_bound1;
  assign inner_wrap = (it0_q == bound0_q - ONE);
  assign is_last    = (state_q == S_RUN) && inner_wrap && (it1_q == bound1_q - ONE);
  assign hs         = (state_q == S_RUN) && bus.iter_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    bound0_d     = bound0_q;
    bound1_d     = bound1_q;
    it0_d        = it0_q;
    it1_d        = it1_q;
    case (state_q)
      S_IDLE: begin
        if (gnt != 2'b00) begin
          last_grant_d = gnt[1];
          owner_d      = gnt[1];
          bound0_d     = sel_b0;
          bound1_d     = sel_b1;
          it0_d        = '0;
          it1_d        = '0;
          // A zero trip count in either dimension means no iterations at all.
          state_d      = ((sel_b0 == '0) || (sel_b1 == '0)) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (hs) begin
          if (is_last) begin
            state_d = S_DONE;
          end else if (inner_wrap) begin
            it0_d = '0;
            it1_d = it1_q + ONE;
          end else begin
            it0_d = it0_q + ONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      bound0_q     <= '0;
      bound1_q     <= '0;
      it0_q        <= '0;
      it1_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      bound0_q     <= bound0_d;
      bound1_q     <= bound1_d;
      it0_q        <= it0_d;
      it1_q        <= it1_d;
    end
  end

  assign bus.req_ready  = gnt;
  assign bus.iter_valid = (state_q == S_RUN);
  assign bus.iter0      = it0_q;
  assign bus.iter1      = it1_q;
  assign bus.iter_last  = is_last;
  assign bus.iter_owner = owner_q;
  assign bus.done       = (state_q == S_DONE);
  assign bus.done_owner = (state_q == S_DONE) && owner_q;

endmodule

// File: tb/tb_loop_nest_sched.sv
module tb_loop_nest_sched;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  loop_nest_sched_if #(.WIDTH(8)) bus ();

  loop_nest_sched #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".req_ready"},  {30'd0, bus.req_ready}, 0);
    chk({tag, ".iter_valid"}, {31'd0, bus.iter_valid}, 0);
    chk({tag, ".iter0"},      {24'd0, bus.iter0}, 0);
    chk({tag, ".iter1"},      {24'd0, bus.iter1}, 0);
    chk({tag, ".iter_last"},  {31'd0, bus.iter_last}, 0);
    chk({tag, ".iter_owner"}, {31'd0, bus.iter_owner}, 0);
    chk({tag, ".done"},       {31'd0, bus.done}, 0);
    chk({tag, ".done_owner"}, {31'd0, bus.done_owner}, 0);
  endtask

  // Called right after the accept edge; walks the whole job against a small
  // index model, then checks the done pulse and the return to idle.
  // mode 0: iter_ready always 1; mode 1: ready pattern 1,0,0,1,0,0...
  task automatic run_job(input int own, input int b0, input int b1, input int mode);
    int e0 = 0;
    int e1 = 0;
    int hs = 0;
    int cyc = 0;
    int n = b0 * b1;
    bit exp_last;
    while (hs < n && cyc < 400) begin
      bus.iter_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      exp_last = (e0 == b0 - 1) && (e1 == b1 - 1);
      chk("iter_valid", {31'd0, bus.iter_valid}, 1);
      chk("iter0",      {24'd0, bus.iter0}, e0);
      chk("iter1",      {24'd0, bus.iter1}, e1);
      chk("iter_last",  {31'd0, bus.iter_last}, {31'd0, exp_last});
      chk("iter_owner", {31'd0, bus.iter_owner}, own);
      chk("done_in_run", {31'd0, bus.done}, 0);
      tick();
      if (bus.iter_ready) begin
        hs++;
        if (e0 == b0 - 1) begin
          e0 = 0;
          e1++;
        end else begin
          e0++;
        end
      end
      cyc++;
    end
    chk("handshakes", hs, n);
    chk("done_pulse", {31'd0, bus.done}, 1);
    chk("done_owner", {31'd0, bus.done_owner}, own);
    chk("valid_in_done", {31'd0, bus.iter_valid}, 0);
    tick();
    chk("done_cleared", {31'd0, bus.done}, 0);
    chk("valid_in_idle", {31'd0, bus.iter_valid}, 0);
  endtask

  // Present a single request, expect an immediate grant, accept it.
  task automatic accept(input int own, input int b0, input int b1);
    if (own == 0) begin
      bus.req0_bound0 = 8'(b0);
      bus.req0_bound1 = 8'(b1);
      bus.req_valid   = 2'b01;
    end else begin
      bus.req1_bound0 = 8'(b0);
      bus.req1_bound1 = 8'(b1);
      bus.req_valid   = 2'b10;
    end
    #1;
    chk("grant", {30'd0, bus.req_ready}, (own == 0) ? 1 : 2);
    tick();
    bus.req_valid = 2'b00;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.req_valid   = 2'b00;
    bus.req0_bound0 = 8'd0;
    bus.req0_bound1 = 8'd0;
    bus.req1_bound0 = 8'd0;
    bus.req1_bound1 = 8'd0;
    bus.iter_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_all_zero("idle");

    // Single 4x3 job, no backpressure.
    accept(0, 4, 3);
    run_job(0, 4, 3, 0);

    // Same job with iter_ready toggling 1,0,0.
    accept(0, 4, 3);
    run_job(0, 4, 3, 1);

    // Bound change after acceptance must not affect the running job.
    accept(0, 4, 3);
    bus.req0_bound0 = 8'd7;
    run_job(0, 4, 3, 0);

    // Zero-trip job from requester 1.
    accept(1, 0, 5);
    chk("zt_valid", {31'd0, bus.iter_valid}, 0);
    chk("zt_done", {31'd0, bus.done}, 1);
    chk("zt_done_owner", {31'd0, bus.done_owner}, 1);
    tick();
    chk("zt_done_cleared", {31'd0, bus.done}, 0);
    chk("zt_valid_after", {31'd0, bus.iter_valid}, 0);
    bus.req_valid = 2'b01;
    #1;
    chk("zt_back_idle", {30'd0, bus.req_ready}, 1);
    bus.req_valid = 2'b00;
    tick();

    // Async reset mid-job at (1,2); last grant before reset was requester 0.
    accept(0, 4, 3);
    bus.iter_ready = 1'b1;
    repeat (6) tick();
    chk("pre_rst_iter1", {24'd0, bus.iter1}, 1);
    chk("pre_rst_iter0", {24'd0, bus.iter0}, 2);
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    repeat (2) begin
      tick();
      chk("rst_no_done", {31'd0, bus.done}, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.iter_ready  = 1'b0;
    bus.req0_bound0 = 8'd2;
    bus.req0_bound1 = 8'd1;
    bus.req1_bound0 = 8'd2;
    bus.req1_bound1 = 8'd1;
    tick();
    chk("post_rst_no_done", {31'd0, bus.done}, 0);

    // Round-robin with both requests held: order 0,1,0,1, 2-cycle gap between jobs.
    bus.req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rr_grant", {30'd0, bus.req_ready}, ((k % 2) == 0) ? 1 : 2);
      tick();
      run_job(k % 2, 2, 1, 0);
    end
    bus.req_valid = 2'b00;
    #1;
    chk("final_idle", {30'd0, bus.req_ready}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/loop_nest_sched.md
# loop_nest_sched

Two-requester scheduler for a shared two-level nested loop iterator. Each requester submits a job (inner and outer trip counts). The block arbitrates round-robin, then runs the granted loop nest one iteration per accepted handshake on a valid/ready iteration stream, and pulses completion. It sits between the control logic and the loop-driven datapath it sequences.

## Interface
- WIDTH, 8, bit width of trip counts and iteration indices

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  2  per-requester job request; bit i = requester i
- req_ready  out  2  per-requester grant/accept; one-hot or zero
- req0_bound0  in  WIDTH  requester 0 inner trip count (iter0 runs 0..bound0-1)
- req0_bound1  in  WIDTH  requester 0 outer trip count
- req1_bound0  in  WIDTH  requester 1 inner trip count
- req1_bound1  in  WIDTH  requester 1 outer trip count
- iter_valid  out  1  current iteration valid
- iter_ready  in  1  downstream accepts current iteration
- iter0  out  WIDTH  inner index
- iter1  out  WIDTH  outer index
- iter_last  out  1  current iteration is the final one of the job
- iter_owner  out  1  requester that owns the running job
- done  out  1  one-cycle pulse when a job completes
- done_owner  out  1  requester whose job completed; valid while done=1

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - req_ready is combinational. The arbitration winner among asserted req_valid bits gets its bit set; all other bits are 0.
  - A bit is never set outside IDLE or when the matching req_valid is 0.
- Arbitration:
  - Round-robin with a 1-bit `last_grant` register. Reset value is 1, so requester 0 wins a first simultaneous request.
  - When both requests are valid, the winner is the requester that is not `last_grant`. `last_grant` updates on every accepted request.
- Accept (req_valid[i] & req_ready[i]):
  - Latch that requester's bound0/bound1 and set owner=i.
  - Set iter0=iter1=0.
  - If bound0==0 or bound1==0 (zero-trip), go to DONE. Otherwise go to RUN.
- RUN:
  - iter_valid=1.
  - On iter_valid & iter_ready with iter_last=0: iter0 increments. When iter0==bound0-1 it wraps to 0 and iter1 increments.
  - On iter_valid & iter_ready with iter_last=1: go to DONE.
  - Without iter_ready, iter0, iter1, iter_last and iter_owner hold stable.
- iter_last = (iter0==bound0-1) & (iter1==bound1-1), decoded from registers.
- DONE: done=1 and done_owner=owner for exactly one cycle, then IDLE.
- Requests that arrive in RUN or DONE wait. req_valid must stay asserted until accepted; a request dropped before acceptance is ignored.
- Latched bounds are unaffected by changes on req*_bound* after acceptance.
- Total iterations per job = bound0*bound1. The maximum bound is 2^WIDTH-1. Index arithmetic is WIDTH bits and never overflows within a job.

## Timing
- Reset values: req_ready=0, iter_valid=0, iter0=0, iter1=0, iter_last=0, iter_owner=0, done=0, done_owner=0.
- rst asserted mid-job: all outputs clear asynchronously and the job is discarded. No done pulse is produced for it.
- Grant → first iteration: acceptance at edge N gives iter_valid=1 with (0,0) from cycle N+1.
- Throughput: one iteration per cycle while iter_ready=1.
- Final handshake at edge M gives done=1 in cycle M+1 and IDLE in cycle M+2, so the next grant is accepted at edge M+2 at the earliest.
- Zero-trip job: accept at edge N, done=1 in cycle N+1, iter_valid never asserts.
- Simultaneous requests are resolved by `last_grant`; exactly one is accepted per IDLE cycle.

## Test plan
- Single job: req0 with bound0=4, bound1=3, iter_ready=1.
  - Required: 12 iterations in consecutive cycles, (iter1,iter0) = (0,0),(0,1)…(0,3),(1,0)…(2,3).
  - iter_last=1 only on (2,3); done=1 with done_owner=0 one cycle after.
- Backpressure: same job, iter_ready toggling 1,0,0,1…
  - Required: indices hold while ready=0, no iteration is skipped or duplicated, and total handshakes = 12.
- Round-robin: both req_valid held high, each job 2×1, out of reset.
  - Required grant order 0,1,0,1; done_owner follows the same order.
  - Each job yields 2 iterations; a 2-cycle gap separates jobs.
- Zero-trip: req1 with bound0=0, bound1=5.
  - Required: iter_valid stays 0, done=1 with done_owner=1 one cycle after acceptance, block back in IDLE.
- Async reset mid-job: assert rst while a 4×3 job is at (1,2).
  - Required: iter_valid=0 and all outputs zero before the next edge, no done pulse.
  - After release, req0 is granted first again.
- Bound hold: change req0_bound0 from 4 to 7 one cycle after acceptance.
  - Required: the job still wraps iter0 at 3.
